hex_digit_counter: RTL and testbench

HEX_DIGIT_COUNTER -- requirements
Module: hex_digit_counter

---
 rtl/hex_digit_counter.sv | 149 ++++++++++++++
 tb/tb_hex_digit_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hex_digit_counter.sv
// Single-digit up/down counter with debounced buttons, an auto-increment prescaler and a clamped load.
// Wraps raise one-cycle carry (cout) or borrow (bout) pulses.

module hex_digit_counter_db #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic           sync1_q, sync2_q;
  logic           db_q, db_d;
  logic           db_prev_q;
  logic           press_q, press_d;
  logic [DBW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d    = db_q;
    cnt_d   = cnt_q;
    press_d = db_q & ~db_prev_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      // Enough consecutive differing samples: accept the new level.
      db_d  = ~db_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      press_q   <= press_d;
      cnt_q     <= cnt_d;
    end
  end

  assign press_o = press_q;
endmodule

module hex_digit_counter #(
  parameter int MODULUS   = 10,
  parameter int DB_CYCLES = 250000,
  parameter int TICK_DIV  = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       auto_en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       cout,
  output logic       bout
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    CNT_MAX    = 4'(MODULUS - 1);
  localparam logic [4:0]    MOD5       = 5'(MODULUS);

  logic          up_ev, down_ev, tick;
  logic [3:0]    count_q, count_d;
  logic          cout_q, cout_d;
  logic          bout_q, bout_d;
  logic [PW-1:0] presc_q, presc_d;

  hex_digit_counter_db #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk_i   (clock),
    .rst_ni  (reset),
    .btn_i   (btn_up),
    .press_o (up_ev)
  );

  hex_digit_counter_db #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk_i   (clock),
    .rst_ni  (reset),
    .btn_i   (btn_down),
    .press_o (down_ev)
  );

  assign tick = auto_en && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (!auto_en || tick) presc_d = '0;
    else                  presc_d = presc_q + 1'b1;
  end

  always_comb begin
    count_d = count_q;
    cout_d  = 1'b0;
    bout_d  = 1'b0;
    if (load) begin
      count_d = ({1'b0, load_val} < MOD5) ? load_val : CNT_MAX;
    end else if (up_ev && down_ev) begin
      count_d = count_q;
    end else if (up_ev || (!down_ev && tick)) begin
      // A tick is only honoured when nothing else acts this cycle.
      if (count_q == CNT_MAX) begin
        count_d = 4'd0;
        cout_d  = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end else if (down_ev) begin
      if (count_q == 4'd0) begin
        count_d = CNT_MAX;
        bout_d  = 1'b1;
      end else begin
        count_d = count_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= 4'd0;
      cout_q  <= 1'b0;
      bout_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      count_q <= count_d;
      cout_q  <= cout_d;
      bout_q  <= bout_d;
      presc_q <= presc_d;
    end
  end

  assign count = count_q;
  assign cout  = cout_q;
  assign bout  = bout_q;
endmodule

// File: tb/tb_hex_digit_counter.sv
// Directed bench for hex_digit_counter with MODULUS=10, DB_CYCLES=4, TICK_DIV=5.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.

module tb_hex_digit_counter;
  logic       clock;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic       auto_en;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       cout;
  logic       bout;

  int n_tests;
  int n_fail;

  hex_digit_counter #(.MODULUS(10), .DB_CYCLES(4), .TICK_DIV(5)) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .auto_en  (auto_en),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .cout     (cout),
    .bout     (bout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load     = 1'b1;
    load_val = v;
    step(1);
    load     = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    auto_en  = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;

    step(2);
    check("rst_count", {4'd0, count}, 8'd0);
    check("rst_cout", {7'd0, cout}, 8'd0);
    check("rst_bout", {7'd0, bout}, 8'd0);
    reset = 1'b1;
    step(2);
    check("idle_count", {4'd0, count}, 8'd0);

    // Clean press from 3: change lands on the 8th edge after first sample.
    do_load(4'd3);
    check("load3", {4'd0, count}, 8'd3);
    btn_up = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check("clean_cout", {7'd0, cout}, 8'd0);
      if (i == 7) check("clean_edge7", {4'd0, count}, 8'd3);
    end
    check("clean_edge8", {4'd0, count}, 8'd4);
    btn_up = 1'b0;
    step(12);
    check("release_no_ev", {4'd0, count}, 8'd4);

    // Bounce then hold: one increment only.
    btn_up = 1'b1; step(1);
    btn_up = 1'b0; step(1);
    btn_up = 1'b1; step(1);
    btn_up = 1'b0; step(1);
    btn_up = 1'b1; step(20);
    check("bounce_once", {4'd0, count}, 8'd5);
    btn_up = 1'b0; step(12);

    // Short release/re-press while held produces no extra event.
    btn_up = 1'b1; step(12);
    check("hold_inc", {4'd0, count}, 8'd6);
    btn_up = 1'b0; step(2);
    btn_up = 1'b1; step(12);
    check("short_release", {4'd0, count}, 8'd6);
    btn_up = 1'b0; step(12);

    // Wrap up from 9, then wrap down from 0.
    do_load(4'd9);
    btn_up = 1'b1;
    step(7);
    check("wrapup_pre", {4'd0, count}, 8'd9);
    check("wrapup_pre_cout", {7'd0, cout}, 8'd0);
    step(1);
    check("wrapup_count", {4'd0, count}, 8'd0);
    check("wrapup_cout", {7'd0, cout}, 8'd1);
    check("wrapup_bout", {7'd0, bout}, 8'd0);
    step(1);
    check("wrapup_cout_end", {7'd0, cout}, 8'd0);
    btn_up = 1'b0; step(12);
    btn_down = 1'b1;
    step(8);
    check("wrapdn_count", {4'd0, count}, 8'd9);
    check("wrapdn_bout", {7'd0, bout}, 8'd1);
    check("wrapdn_cout", {7'd0, cout}, 8'd0);
    step(1);
    check("wrapdn_bout_end", {7'd0, bout}, 8'd0);
    btn_down = 1'b0; step(12);

    // Plain decrement, and simultaneous up+down cancels.
    btn_down = 1'b1; step(12);
    check("dec", {4'd0, count}, 8'd8);
    btn_down = 1'b0; step(12);
    do_load(4'd5);
    btn_up = 1'b1; btn_down = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("both_cout", {7'd0, cout}, 8'd0);
      check("both_bout", {7'd0, bout}, 8'd0);
    end
    check("both_count", {4'd0, count}, 8'd5);
    btn_up = 1'b0; btn_down = 1'b0; step(12);

    // Auto-increment: 25 cycles -> 5 ticks; restart after a gap.
    do_load(4'd0);
    auto_en = 1'b1;
    step(25);
    check("auto25", {4'd0, count}, 8'd5);
    auto_en = 1'b0;
    step(3);
    check("auto_off", {4'd0, count}, 8'd5);
    auto_en = 1'b1;
    step(4);
    check("auto_restart4", {4'd0, count}, 8'd5);
    step(1);
    check("auto_restart5", {4'd0, count}, 8'd6);
    auto_en = 1'b0;
    step(2);

    // Load of 12 clamps to 9 and swallows a coincident up event.
    do_load(4'd3);
    btn_up = 1'b1;
    step(7);
    load = 1'b1; load_val = 4'd12;
    step(1);
    load = 1'b0;
    check("load_clamp", {4'd0, count}, 8'd9);
    check("load_cout", {7'd0, cout}, 8'd0);
    step(2);
    check("load_ev_lost", {4'd0, count}, 8'd9);
    check("load_ev_cout", {7'd0, cout}, 8'd0);
    btn_up = 1'b0; step(12);
    do_load(4'd15);
    check("load15", {4'd0, count}, 8'd9);

    // Reset mid-debounce, button held through release.
    do_load(4'd7);
    btn_up = 1'b1;
    step(4);
    #2 reset = 1'b0;
    #1;
    check("async_rst_count", {4'd0, count}, 8'd0);
    check("async_rst_cout", {7'd0, cout}, 8'd0);
    step(2);
    reset = 1'b1;
    step(7);
    check("post_rst_edge7", {4'd0, count}, 8'd0);
    step(1);
    check("post_rst_edge8", {4'd0, count}, 8'd1);
    step(20);
    check("post_rst_once", {4'd0, count}, 8'd1);
    btn_up = 1'b0; step(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
